riscv_fetch_unit: RTL and testbench

RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

---
 rtl/riscv_fetch_unit_if.sv | 24 ++
 rtl/riscv_fetch_unit.sv | 103 ++++++++++
 tb/tb_riscv_fetch_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// The master drives the request and address; the slave returns data and ready.
`timescale 1ns/1ps

interface riscv_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );
endinterface

// File: rtl/riscv_fetch_unit.sv
// Multi-cycle RISC-V fetch stage: request, hold one instruction until it is
// consumed, commit the next PC, and trap permanently on a misaligned target.
`timescale 1ns/1ps

module riscv_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   riscv_fetch_unit_if.master        imem,
   input  logic [1:0]                PCSrc,
   input  logic [31:0]               ImmExt,
   input  logic [31:0]               ALUResult,
   input  logic                      exec_done,
   output logic [31:0]               instr,
   output logic [31:0]               pc,
   output logic [31:0]               pc_plus4,
   output logic                      instr_valid,
   output logic                      misaligned,
   output logic [31:0]               instret
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH,
      VALID,
      FAULT
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] next_pc;
   logic        load_instr;
   logic        commit;
   logic        next_misaligned;

   assign pc_plus4       = pc + 32'd4;
   assign imem.imem_addr = pc;
   assign imem.imem_req  = (state == FETCH);
   assign instr_valid    = (state == VALID);

   // jalr target clears bit 0; masking keeps every ALUResult bit in use
   always_comb begin
      next_pc = pc_plus4;
      case (PCSrc)
         2'b01:   next_pc = pc + ImmExt;
         2'b10:   next_pc = ALUResult & ~32'h0000_0001;
         default: next_pc = pc_plus4;
      endcase
   end

   assign next_misaligned = (next_pc[1:0] != 2'b00);

   always_comb begin
      state_next = state;
      load_instr = 1'b0;
      commit     = 1'b0;
      case (state)
         FETCH: begin
            if (imem.imem_ready) begin
               load_instr = 1'b1;
               state_next = VALID;
            end
         end
         VALID: begin
            if (exec_done) begin
               commit     = 1'b1;
               state_next = next_misaligned ? FAULT : FETCH;
            end
         end
         FAULT: begin
            state_next = FAULT;
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         instr      <= NOP_INSTR;
         instret    <= '0;
         misaligned <= 1'b0;
      end else begin
         state <= state_next;
         if (load_instr) begin
            instr <= imem.imem_rdata;
         end
         if (commit) begin
            pc      <= next_pc;
            instret <= instret + 32'd1;
            if (next_misaligned) begin
               misaligned <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboarded bench for riscv_fetch_unit: fetched words and their PCs are
// queued when memory answers and checked when the instruction becomes valid.
`timescale 1ns/1ps

module tb_riscv_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  PCSrc;
   logic [31:0] ImmExt;
   logic [31:0] ALUResult;
   logic        exec_done;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        misaligned;
   logic [31:0] instret;

   riscv_fetch_unit_if bus ();

   riscv_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (bus.master),
      .PCSrc       (PCSrc),
      .ImmExt      (ImmExt),
      .ALUResult   (ALUResult),
      .exec_done   (exec_done),
      .instr       (instr),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid),
      .misaligned  (misaligned),
      .instret     (instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [31:0] model_pc;
   logic [31:0] model_instret;
   logic        model_mis;
   logic [31:0] model_instr;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic req, input logic vld);
      check_eq({tag, "_req"},      {31'd0, bus.imem_req}, {31'd0, req});
      check_eq({tag, "_valid"},    {31'd0, instr_valid},  {31'd0, vld});
      check_eq({tag, "_addr"},     bus.imem_addr,         model_pc);
      check_eq({tag, "_pc"},       pc,                    model_pc);
      check_eq({tag, "_pc_plus4"}, pc_plus4,              model_pc + 32'd4);
      check_eq({tag, "_instret"},  instret,               model_instret);
      check_eq({tag, "_mis"},      {31'd0, misaligned},   {31'd0, model_mis});
      check_eq({tag, "_instr"},    instr,                 model_instr);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_pc      = RESET_PC;
      model_instret = '0;
      model_mis     = 1'b0;
      model_instr   = NOP_INSTR;
      sb.delete();
      check_state("reset", 1'b1, 1'b0);
   endtask

   // Entered at a falling edge with the DUT in FETCH
   task automatic fetch(input logic [31:0] rdata, input int waits, input logic noise);
      int   cyc;
      exp_t e;
      for (int w = 0; w < waits; w++) begin
         bus.imem_ready = 1'b0;
         exec_done      = noise;
         PCSrc          = 2'b01;
         ImmExt         = 32'h0000_0040;
         @(negedge clk);
         check_state("fetch_wait", 1'b1, 1'b0);
      end
      exec_done      = 1'b0;
      bus.imem_ready = 1'b1;
      bus.imem_rdata = rdata;
      sb.push_back('{instr: rdata, pc: model_pc});
      @(negedge clk);
      bus.imem_ready = 1'b0;
      bus.imem_rdata = ~rdata;
      cyc = 0;
      while (!instr_valid && cyc < 4) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("fetch_latency", cyc, 0);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_eq("sb_instr", instr, e.instr);
         check_eq("sb_pc", pc, e.pc);
         model_instr = e.instr;
      end
      check_state("valid", 1'b0, 1'b1);
   endtask

   task automatic commit(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
      logic [31:0] npc;
      case (src)
         2'b01:   npc = model_pc + imm;
         2'b10:   npc = {alu[31:1], 1'b0};
         default: npc = model_pc + 32'd4;
      endcase
      PCSrc     = src;
      ImmExt    = imm;
      ALUResult = alu;
      exec_done = 1'b1;
      model_pc      = npc;
      model_instret = model_instret + 32'd1;
      if (npc[1:0] != 2'b00) model_mis = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      check_state("commit", !model_mis, 1'b0);
   endtask

   task automatic hold_valid(input int n);
      for (int i = 0; i < n; i++) begin
         bus.imem_ready = 1'b1;
         bus.imem_rdata = $urandom;
         exec_done      = 1'b0;
         @(negedge clk);
         check_state("hold", 1'b0, 1'b1);
      end
      bus.imem_ready = 1'b0;
   endtask

   task automatic fault_idle(input int n);
      for (int i = 0; i < n; i++) begin
         exec_done      = 1'b1;
         bus.imem_ready = 1'b1;
         bus.imem_rdata = $urandom;
         PCSrc          = 2'($urandom_range(0, 3));
         ImmExt         = 32'h0000_0004;
         ALUResult      = 32'h0000_0200;
         @(negedge clk);
         check_state("fault", 1'b0, 1'b0);
      end
      exec_done      = 1'b0;
      bus.imem_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  src;
      logic [31:0] imm;
      logic [31:0] alu;
      rst            = 1'b1;
      PCSrc          = 2'b00;
      ImmExt         = '0;
      ALUResult      = '0;
      exec_done      = 1'b0;
      bus.imem_ready = 1'b0;
      bus.imem_rdata = '0;
      @(negedge clk);
      do_reset();

      // First fetch straight out of reset, then jalr to 0x10 and a backward branch
      fetch(32'h0050_0093, 0, 1'b0);
      commit(2'b10, 32'h0, 32'h0000_0011);
      fetch(32'h0010_0113, 0, 1'b0);
      commit(2'b01, 32'hFFFF_FFF8, 32'h0);

      // Five stalled cycles with exec_done noise, then a held VALID
      fetch(32'h1234_5678, 5, 1'b1);
      hold_valid(3);
      commit(2'b11, 32'h0000_0100, 32'h0000_0200);

      // PC wrap at the top of the address space
      fetch(32'h0000_0067, 0, 1'b0);
      commit(2'b10, 32'h0, 32'hFFFF_FFFD);
      fetch(32'h0000_006F, 1, 1'b0);
      commit(2'b00, 32'h0, 32'h0);

      // Random aligned traffic
      for (int i = 0; i < 12; i++) begin
         fetch($urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         src = 2'($urandom_range(0, 3));
         imm = $urandom & 32'hFFFF_FFFC;
         alu = $urandom & 32'hFFFF_FFFD;
         commit(src, imm, alu);
      end

      // Reset while a fetch is outstanding and memory answers in the same cycle
      rst            = 1'b1;
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      rst            = 1'b0;
      bus.imem_ready = 1'b0;
      model_pc      = RESET_PC;
      model_instret = '0;
      model_mis     = 1'b0;
      model_instr   = NOP_INSTR;
      sb.delete();
      check_state("rst_fetch", 1'b1, 1'b0);

      // Misaligned jalr target traps permanently
      fetch(32'h0000_8067, 0, 1'b0);
      commit(2'b00, 32'h0, 32'h0);
      fetch(32'h0000_0067, 2, 1'b0);
      commit(2'b10, 32'h0, 32'h0000_0103);
      check_eq("jalr_pc", pc, 32'h0000_0102);
      fault_idle(5);

      // Misaligned branch target also traps; reset clears the fault
      do_reset();
      fetch(32'h0000_0063, 0, 1'b0);
      commit(2'b01, 32'h0000_0002, 32'h0);
      fault_idle(2);
      do_reset();
      fetch(32'h0000_0013, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
